// File: rtl/e203_thread_sched.sv
// e203_thread_sched: hardware thread scheduler for the multithreaded E203 core.
// Picks the active hardware thread round-robin, decides when to switch (slice
// expiry, long-latency stall, or retirement of the current thread), and
// sequences the switch with the IFU through a req/ack drain handshake.
module e203_thread_sched #(
    parameter int THREADS_NUM = 2,
    parameter int SLICE_W     = 10,
    parameter int MIN_RES     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [THREADS_NUM-1:0] thread_valid,
    input  logic [THREADS_NUM-1:0] thread_wait,
    input  logic                   long_inst,
    input  logic                   bjp,
    input  logic                   ifetch_wait,
    input  logic [SLICE_W-1:0]     slice_cfg,
    input  logic                   switch_ack,
    output logic                   switch_req,
    output logic                   switch_en,
    output logic [THREADS_NUM-1:0] thread_sel,
    output logic [THREADS_NUM-1:0] thread_sel_next,
    output logic [1:0]             cur_tid
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         cur_tid_q, cur_tid_d;
    logic [1:0]         target_q, target_d;
    logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
    logic [SLICE_W-1:0] res_cnt_q, res_cnt_d;

    // Per-thread status widened to the 4-thread maximum so a 2-bit thread
    // index can address it for any THREADS_NUM.
    logic [3:0] valid_ext;
    logic [3:0] wait_ext;
    logic [3:0] cand;

    logic       rr_found;
    logic [1:0] rr_pick;
    logic [2:0] rr_idx;

    logic       slice_hit;
    logic       stall_hit;
    logic       retire_hit;
    logic       trigger;
    logic       target_ok;
    logic       eff_found;
    logic [1:0] eff_target;

    // Switch candidates: enabled, not blocked, and not the running thread.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        valid_ext = '0;
        wait_ext  = '0;
        for (int t = 0; t < THREADS_NUM; t++) begin
            valid_ext[t] = thread_valid[t];
            wait_ext[t]  = thread_wait[t];
        end
        cand            = valid_ext & ~wait_ext;
        cand[cur_tid_q] = 1'b0;
    end

    // Round-robin pick: first candidate at cur+1, cur+2, ... modulo THREADS_NUM.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = cur_tid_q;
        rr_idx   = '0;
        for (int k = 1; k < THREADS_NUM; k++) begin
            rr_idx = {1'b0, cur_tid_q} + 3'(k);
            if (rr_idx >= 3'(THREADS_NUM)) begin
                rr_idx = rr_idx - 3'(THREADS_NUM);
            end
            if (!rr_found && cand[rr_idx[1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx[1:0];
            end
        end
    end

    // Switch triggers evaluated against the live slice_cfg (no latching) and
    // the effective drain target, re-picked if the latched one dropped out.
    always_comb begin
        slice_hit  = (slice_cfg != '0) && (slice_cnt_q >= (slice_cfg - SLICE_W'(1)));
        stall_hit  = (long_inst | wait_ext[cur_tid_q]) && (res_cnt_q >= SLICE_W'(MIN_RES));
        retire_hit = ~valid_ext[cur_tid_q];
        trigger    = rr_found && (slice_hit || stall_hit || retire_hit);
        target_ok  = cand[target_q];
        eff_found  = target_ok || rr_found;
        eff_target = target_ok ? target_q : rr_pick;
    end

    // Next-state logic: RUN counts and watches for a trigger, DRAIN waits for
    // the IFU handshake and commits the switch in the same cycle as the ack.
    always_comb begin
        state_d     = state_q;
        cur_tid_d   = cur_tid_q;
        target_d    = target_q;
        slice_cnt_d = slice_cnt_q;
        res_cnt_d   = res_cnt_q;
        switch_en   = 1'b0;
        case (state_q)
            ST_RUN: begin
                slice_cnt_d = (&slice_cnt_q) ? slice_cnt_q : slice_cnt_q + SLICE_W'(1);
                res_cnt_d   = (&res_cnt_q) ? res_cnt_q : res_cnt_q + SLICE_W'(1);
                if (trigger) begin
                    state_d  = ST_DRAIN;
                    target_d = rr_pick;
                end
            end
            ST_DRAIN: begin
                if (!eff_found) begin
                    // Nobody left to switch to: abandon, keep counters so the
                    // trigger can fire again once a candidate reappears.
                    state_d = ST_RUN;
                end else begin
                    target_d = eff_target;
                    if (switch_ack && !bjp && !ifetch_wait) begin
                        switch_en   = 1'b1;
                        cur_tid_d   = eff_target;
                        slice_cnt_d = '0;
                        res_cnt_d   = '0;
                        state_d     = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and counter registers with synchronous reset to thread 0 / RUN.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_RUN;
            cur_tid_q   <= '0;
            target_q    <= '0;
            slice_cnt_q <= '0;
            res_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_tid_q   <= cur_tid_d;
            target_q    <= target_d;
            slice_cnt_q <= slice_cnt_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    // One-hot select derived from the binary index, so it is one-hot by construction.
    always_comb begin
        thread_sel      = '0;
        thread_sel_next = '0;
        for (int t = 0; t < THREADS_NUM; t++) begin
            thread_sel[t]      = (cur_tid_q == 2'(t));
            thread_sel_next[t] = (cur_tid_d == 2'(t));
        end
    end

    assign switch_req = (state_q == ST_DRAIN);
    assign cur_tid    = cur_tid_q;

endmodule
